// File: rtl/spi_fb_writer.sv
// Converts the SPI slave's RAMWR pixel stream into linear frame-buffer write
// requests, queued in a small FIFO with a valid/ready handshake toward the arbiter.
module spi_fb_writer #(
   parameter int H_RES      = 480,
   parameter int V_RES      = 272,
   parameter int ADDR_W     = 17,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [7:0]        i_inst_data,
   input  logic              i_inst_en_pls,
   input  logic [15:0]       i_row_addr,
   input  logic              i_row_addr_en_pls,
   input  logic [15:0]       i_pixel_data,
   input  logic              i_pixel_en_pls,
   output logic [ADDR_W-1:0] o_wr_addr,
   output logic [15:0]       o_wr_data,
   output logic              o_wr_valid,
   input  logic              i_wr_ready,
   output logic              o_frame_done_pls,
   output logic              o_overflow
);

   localparam int COL_W = $clog2(H_RES);
   localparam int ROW_W = $clog2(V_RES);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_RES - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_RES - 1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE} state_t;

   state_t r_state, w_nextState;

   logic [ROW_W-1:0]  r_rowStart;
   logic [COL_W-1:0]  r_col;
   logic [ROW_W-1:0]  r_row;
   logic [ADDR_W-1:0] r_addr;

   logic [ADDR_W-1:0] r_fifoAddr [FIFO_DEPTH];
   logic [15:0]       r_fifoData [FIFO_DEPTH];
   logic [PTR_W-1:0]  r_wrPtr, r_rdPtr;
   logic [CNT_W-1:0]  r_count;
   logic              r_overflow;
   logic              r_frameDone;

   logic w_isRamwr, w_loadCycle, w_pixelEvent, w_frameEnd;
   logic w_full, w_pop, w_push;

   assign w_isRamwr = i_inst_en_pls && (i_inst_data == 8'h2C);

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_nextState;
   end

   // Any command received while writing ends the write unless it is another RAMWR.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         S_IDLE:  if (w_isRamwr) w_nextState = S_LOAD;
         S_LOAD:  w_nextState = S_WRITE;
         S_WRITE: if (i_inst_en_pls) w_nextState = w_isRamwr ? S_LOAD : S_IDLE;
         default: w_nextState = S_IDLE;
      endcase
   end

   always_comb begin
      w_loadCycle  = 1'b0;
      w_pixelEvent = 1'b0;
      case (r_state)
         S_LOAD:  w_loadCycle  = 1'b1;
         S_WRITE: w_pixelEvent = i_pixel_en_pls && !i_inst_en_pls;
         default: ;
      endcase
   end

   assign w_frameEnd = w_pixelEvent && (r_col == COL_LAST) && (r_row == ROW_LAST);

   always_ff @(posedge i_clk) begin
      if (i_rst)
         r_rowStart <= '0;
      else if (i_row_addr_en_pls)
         r_rowStart <= (i_row_addr < 16'(V_RES)) ? ROW_W'(i_row_addr) : '0;
   end

   // Geometry advances on every accepted pixel event, even when the FIFO drops it.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_col  <= '0;
         r_row  <= '0;
         r_addr <= '0;
      end else if (w_loadCycle) begin
         r_col  <= '0;
         r_row  <= r_rowStart;
         r_addr <= ADDR_W'(r_rowStart) * ADDR_W'(H_RES);
      end else if (w_pixelEvent) begin
         if (w_frameEnd) begin
            r_col  <= '0;
            r_row  <= '0;
            r_addr <= '0;
         end else if (r_col == COL_LAST) begin
            r_col  <= '0;
            r_row  <= r_row + 1'b1;
            r_addr <= r_addr + 1'b1;
         end else begin
            r_col  <= r_col + 1'b1;
            r_addr <= r_addr + 1'b1;
         end
      end
   end

   assign w_full = (r_count == CNT_W'(FIFO_DEPTH));
   assign w_pop  = (r_count != '0) && i_wr_ready;
   assign w_push = w_pixelEvent && (!w_full || w_pop);

   // When full with a pop, the write slot equals the head being read, so overwrite is safe.
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_fifoAddr[r_wrPtr] <= r_addr;
         r_fifoData[r_wrPtr] <= i_pixel_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
         if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_overflow  <= 1'b0;
         r_frameDone <= 1'b0;
      end else begin
         if (w_pixelEvent && !w_push) r_overflow <= 1'b1;
         r_frameDone <= w_frameEnd;
      end
   end

   // Head is masked while empty so stale storage never shows on the bus.
   assign o_wr_valid       = (r_count != '0);
   assign o_wr_addr        = o_wr_valid ? r_fifoAddr[r_rdPtr] : '0;
   assign o_wr_data        = o_wr_valid ? r_fifoData[r_rdPtr] : '0;
   assign o_frame_done_pls = r_frameDone;
   assign o_overflow       = r_overflow;

endmodule

// File: tb/tb_spi_fb_writer.sv
// Self-checking bench for spi_fb_writer: directed scenarios plus a randomized phase,
// compared every cycle against a linear-address queue model of the write stream.
module tb_spi_fb_writer;

   localparam int H_RES = 480;
   localparam int V_RES = 272;
   localparam int FRAME = H_RES * V_RES;
   localparam int DEPTH = 4;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic [7:0]  i_inst_data;
   logic        i_inst_en_pls;
   logic [15:0] i_row_addr;
   logic        i_row_addr_en_pls;
   logic [15:0] i_pixel_data;
   logic        i_pixel_en_pls;
   logic [16:0] o_wr_addr;
   logic [15:0] o_wr_data;
   logic        o_wr_valid;
   logic        i_wr_ready;
   logic        o_frame_done_pls;
   logic        o_overflow;

   int checks = 0;
   int failures = 0;
   int doneCount = 0;
   int readyMode = 1;

   // Reference model: mode 0 idle, 1 one-cycle load pending, 2 writing.
   int  mMode = 0;
   int  mRowStart = 0;
   int  mAddr = 0;
   int  qAddr[$];
   int  qData[$];
   bit  mOverflow = 0;
   bit  mDoneNext = 0;
   bit  mPop = 0;
   bit  started = 0;

   spi_fb_writer #(.H_RES(H_RES), .V_RES(V_RES), .ADDR_W(17), .FIFO_DEPTH(DEPTH)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_inst_data(i_inst_data), .i_inst_en_pls(i_inst_en_pls),
      .i_row_addr(i_row_addr), .i_row_addr_en_pls(i_row_addr_en_pls),
      .i_pixel_data(i_pixel_data), .i_pixel_en_pls(i_pixel_en_pls),
      .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data), .o_wr_valid(o_wr_valid),
      .i_wr_ready(i_wr_ready), .o_frame_done_pls(o_frame_done_pls), .o_overflow(o_overflow)
   );

   always #5 i_clk = ~i_clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Compare against the model, then advance the model with the inputs the next edge will sample.
   always @(negedge i_clk) begin
      if (started) begin
         checkOutput("valid", 32'(o_wr_valid), 32'(qAddr.size() > 0));
         if (qAddr.size() > 0) begin
            checkOutput("head_addr", 32'(o_wr_addr), qAddr[0]);
            checkOutput("head_data", 32'(o_wr_data), qData[0]);
         end
         checkOutput("overflow", 32'(o_overflow), 32'(mOverflow));
         checkOutput("frame_done", 32'(o_frame_done_pls), 32'(mDoneNext));
      end
      if (o_frame_done_pls === 1'b1) doneCount++;
      if (i_rst) begin
         mMode = 0; mRowStart = 0; mAddr = 0;
         qAddr.delete(); qData.delete();
         mOverflow = 0; mDoneNext = 0; started = 1;
      end else begin
         mPop = (qAddr.size() > 0) && i_wr_ready;
         if (mPop) begin
            void'(qAddr.pop_front());
            void'(qData.pop_front());
         end
         mDoneNext = 0;
         if (mMode == 1) begin
            mAddr = mRowStart * H_RES;
            mMode = 2;
         end else if (i_inst_en_pls) begin
            mMode = (i_inst_data == 8'h2C) ? 1 : 0;
         end else if (mMode == 2 && i_pixel_en_pls) begin
            if (qAddr.size() < DEPTH) begin
               qAddr.push_back(mAddr);
               qData.push_back(int'(i_pixel_data));
            end else begin
               mOverflow = 1;
            end
            if (mAddr == FRAME - 1) mDoneNext = 1;
            mAddr = (mAddr + 1) % FRAME;
         end
         if (i_row_addr_en_pls) mRowStart = (int'(i_row_addr) < V_RES) ? int'(i_row_addr) : 0;
      end
   end

   task automatic applyStimulus(input logic instEn, input logic [7:0] inst,
                                input logic rowEn, input logic [15:0] row,
                                input logic pixEn, input logic [15:0] pix);
      @(posedge i_clk);
      #1;
      i_inst_en_pls     = instEn;
      i_inst_data       = inst;
      i_row_addr_en_pls = rowEn;
      i_row_addr        = row;
      i_pixel_en_pls    = pixEn;
      i_pixel_data      = pix;
      i_wr_ready        = (readyMode == 2) ? 1'($urandom_range(0, 1)) : (readyMode == 1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 8'h00, 0, 16'h0, 0, 16'h0);
   endtask

   task automatic sendInst(input logic [7:0] b);
      applyStimulus(1, b, 0, 16'h0, 0, 16'h0);
   endtask

   task automatic sendRow(input logic [15:0] r);
      applyStimulus(0, 8'h00, 1, r, 0, 16'h0);
   endtask

   task automatic sendPixel(input logic [15:0] d);
      applyStimulus(0, 8'h00, 0, 16'h0, 1, d);
   endtask

   initial begin
      i_rst = 1'b1;
      i_inst_en_pls = 0; i_inst_data = 0;
      i_row_addr_en_pls = 0; i_row_addr = 0;
      i_pixel_en_pls = 0; i_pixel_data = 0;
      i_wr_ready = 1;
      idle(3);
      checkOutput("rst_valid", 32'(o_wr_valid), 0);
      checkOutput("rst_addr", 32'(o_wr_addr), 0);
      checkOutput("rst_data", 32'(o_wr_data), 0);
      checkOutput("rst_overflow", 32'(o_overflow), 0);
      checkOutput("rst_done", 32'(o_frame_done_pls), 0);
      i_rst = 1'b0;

      // Pixels before any RAMWR are ignored; pixel during LOAD is dropped.
      sendPixel(16'hAAAA);
      sendInst(8'h2C);
      sendPixel(16'hDEAD);
      sendPixel(16'h1111);
      sendPixel(16'h2222);
      sendPixel(16'h3333);
      idle(1);
      checkOutput("ramwr_third_addr", 32'(o_wr_addr), 2);
      idle(3);

      sendRow(16'd5);
      sendInst(8'h2C);
      idle(1);
      sendPixel(16'($urandom));
      idle(1);
      checkOutput("raset5_addr", 32'(o_wr_addr), 2400);
      sendRow(16'd300);
      sendInst(8'h2C);
      idle(1);
      sendPixel(16'($urandom));
      idle(1);
      checkOutput("raset300_addr", 32'(o_wr_addr), 0);

      // Line wrap from row 0, then frame wrap starting on the last row.
      sendRow(16'd0);
      sendInst(8'h2C);
      idle(1);
      for (int i = 0; i < H_RES + 1; i++) sendPixel(16'($urandom));
      idle(1);
      checkOutput("line_wrap_addr", 32'(o_wr_addr), 480);
      sendRow(16'd271);
      sendInst(8'h2C);
      idle(1);
      doneCount = 0;
      for (int i = 0; i < H_RES + 1; i++) sendPixel(16'($urandom));
      idle(1);
      checkOutput("frame_wrap_addr", 32'(o_wr_addr), 0);
      idle(2);
      checkOutput("frame_done_count", doneCount, 1);

      // Backpressure and overflow.
      sendRow(16'd0);
      readyMode = 0;
      sendInst(8'h2C);
      idle(1);
      for (int i = 0; i < 5; i++) sendPixel(16'(16'h0100 + i));
      idle(1);
      checkOutput("bp_overflow", 32'(o_overflow), 1);
      checkOutput("bp_head_addr", 32'(o_wr_addr), 0);
      readyMode = 1;
      idle(6);
      checkOutput("bp_drained", 32'(o_wr_valid), 0);
      sendPixel(16'hBEEF);
      idle(1);
      checkOutput("bp_next_addr", 32'(o_wr_addr), 5);

      // Reset mid-stream with queued entries.
      readyMode = 0;
      for (int i = 0; i < 3; i++) sendPixel(16'($urandom));
      i_rst = 1'b1;
      idle(2);
      checkOutput("midrst_valid", 32'(o_wr_valid), 0);
      checkOutput("midrst_overflow", 32'(o_overflow), 0);
      checkOutput("midrst_addr", 32'(o_wr_addr), 0);
      i_rst = 1'b0;
      readyMode = 1;
      for (int i = 0; i < 3; i++) sendPixel(16'($urandom));
      idle(1);
      checkOutput("midrst_ignored", 32'(o_wr_valid), 0);

      // Abort with a non-RAMWR command, then restart from the latched row.
      sendRow(16'd3);
      sendInst(8'h2C);
      idle(1);
      for (int i = 0; i < 10; i++) sendPixel(16'($urandom));
      sendInst(8'h2A);
      for (int i = 0; i < 5; i++) sendPixel(16'($urandom));
      idle(2);
      checkOutput("abort_ignored", 32'(o_wr_valid), 0);
      sendInst(8'h2C);
      idle(1);
      sendPixel(16'h5A5A);
      idle(1);
      checkOutput("restart_addr", 32'(o_wr_addr), 1440);

      // Randomized traffic with random backpressure.
      readyMode = 2;
      for (int i = 0; i < 2000; i++) begin
         int r;
         r = $urandom_range(0, 99);
         if (r < 2)
            sendInst(8'h2C);
         else if (r < 3)
            sendInst(($urandom_range(0, 1) == 0) ? 8'h2A : 8'h2B);
         else if (r < 4)
            applyStimulus(1, 8'h2C, 0, 16'h0, 1, 16'($urandom));
         else if (r < 6)
            sendRow(16'($urandom_range(0, 400)));
         else if (r < 80)
            sendPixel(16'($urandom));
         else
            idle(1);
      end
      readyMode = 1;
      idle(10);
      checkOutput("final_drained", 32'(o_wr_valid), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
